log_reader_arbiter: RTL and testbench
=====================================

LOG_READER_ARBITER -- requirements
Module: log_reader_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, the number of requesters sharing one log reader (legal range 2..8).
REQ-002 SHALL have parameter LOG_PADBYTES_W, default $clog2(LOG_W/8), the width of the padbytes field.
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-high, rst.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_arb_val  input  NUM_REQ  per-requester read-request valid.
REQ-007 req_arb_addr_start / req_arb_addr_end  input  NUM_REQ x (LOG_HDR_DEPTH_W+1)  per-requester inclusive entry range.
REQ-008 arb_req_rdy  output  NUM_REQ  per-requester request accept.
REQ-009 arb_reader_req_val / arb_reader_addr_start / arb_reader_addr_end  output  1 / LOG_HDR_DEPTH_W+1 / LOG_HDR_DEPTH_W+1  request to the log reader.
REQ-010 reader_arb_req_rdy  input  1  log reader accept.
REQ-011 reader_arb_data_val, _last_view (INT_W), _entries_len (UDP_LENGTH_W), _data (LOG_W), _padbytes (LOG_PADBYTES_W), _last (1)  input  log reader output stream.
REQ-012 arb_reader_data_rdy  output  1  backpressure to the log reader.
REQ-013 arb_req_data_val / arb_req_data_last  output  NUM_REQ  per-requester stream valid/last; data, padbytes, last_view and entries_len are broadcast (shared) outputs.
REQ-014 req_arb_data_rdy  input  NUM_REQ  per-requester stream ready.
REQ-015 arb_busy  output  1  high whenever not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, STREAM.
REQ-017 IDLE: if any req_arb_val, SHALL select winner by round-robin starting at the index after the last-served requester, assert arb_req_rdy only for the winner in that same cycle, latch winner index and its start/end, and go to ISSUE; no other arb_req_rdy bit SHALL ever be high.
REQ-018 ISSUE: SHALL drive arb_reader_req_val=1 with latched start/end; on reader_arb_req_rdy go to STREAM.
REQ-019 STREAM: arb_req_data_val[owner]=reader_arb_data_val, arb_reader_data_rdy=req_arb_data_rdy[owner]; all non-owner valid/last bits 0; non-owner ready ignored.
REQ-020 STREAM: on data val&rdy&last SHALL update last-served to owner and return to IDLE in the next cycle.
REQ-021 Minimum latency request accept -> reader request valid: 1 cycle; a new grant SHALL NOT occur in the cycle the last beat transfers.
REQ-022 Broadcast data fields SHALL be pure combinational pass-through (zero added latency on the stream).
REQ-023 Address ranges SHALL be forwarded unmodified, including wrap-bit (MSB) values; no range checking.
REQ-024 A requester dropping req_arb_val while not granted SHALL lose no state; valid held high across a grant of another requester SHALL be served in round-robin order.
REQ-025 Reader data_val in IDLE or ISSUE SHALL be ignored (arb_reader_data_rdy=0).

Reset
REQ-026 On rst: state=IDLE, last-served=NUM_REQ-1 (so requester 0 has first priority), latched owner/addresses=0.
REQ-027 During/after reset all outputs SHALL be 0: arb_req_rdy, arb_reader_req_val, arb_reader_data_rdy, arb_req_data_val, arb_req_data_last, arb_busy.
REQ-028 Reset mid-STREAM SHALL abort to IDLE immediately; the log reader is reset by the same rst.

Structure
REQ-029 LOG_HDR_DEPTH_W, LOG_W, INT_W and log stream field widths SHALL come from beehive_vr_pkg; no new package types are required.
REQ-030 Round-robin selection SHALL be one sub-module, log_reader_rr_pick (request vector + last index in, one-hot grant + index out, combinational).

Verification
REQ-031 Single requester 0, range 3..5, reader returns 4 beats -> one grant, reader request {3,5}, 4 beats on port 0 with last on beat 4, back to IDLE.
REQ-032 Requesters 0 and 1 both valid from reset -> 0 served first, then 1; third pair of requests -> 0 again.
REQ-033 Owner holds req_arb_data_rdy=0 for 5 cycles mid-stream -> arb_reader_data_rdy=0 for those cycles, no beat lost or duplicated.
REQ-034 Range start=0x1FE, end=0x001 (wrap bit set on start) -> forwarded bit-exact.
REQ-035 Assert rst during STREAM beat 2 -> all outputs 0 next cycle; new request after reset granted normally.
REQ-036 reader_arb_req_rdy held 0 for 10 cycles -> arb_reader_req_val and addresses stable, no arb_req_rdy pulses.

Source files
------------

// File: rtl/beehive_vr_pkg.sv
// beehive_vr_pkg: shared widths for the log header / log stream datapath.
// Consumers import these to size log addresses, log data beats and the
// per-stream metadata that rides alongside the log data.
package beehive_vr_pkg;

  // Log header ring depth; address ports carry one extra wrap bit (MSB).
  localparam int LOG_HDR_DEPTH_W = 8;
  // Log data beat width in bits.
  localparam int LOG_W           = 512;
  // Generic integer field width (view numbers etc.).
  localparam int INT_W           = 32;
  // UDP length field width.
  localparam int UDP_LENGTH_W    = 16;

endpackage

// File: rtl/log_reader_rr_pick.sv
// log_reader_rr_pick: combinational round-robin picker.
// Searches req starting at the index after last_idx and wrapping around.
//   req       : request vector
//   last_idx  : index served most recently
//   grant     : one-hot winner (all zero when nothing requests)
//   grant_idx : binary index of the winner
//   grant_val : any request present
module log_reader_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_val
);

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_idx is the final (winning) assignment.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_val = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      int c;
      c = int'(last_idx) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (req[c]) begin
        grant_val = 1'b1;
        grant_idx = IDX_W'(c);
        grant     = '0;
        grant[c]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/log_reader_arbiter.sv
// log_reader_arbiter: shares one log reader between NUM_REQ requesters.
// IDLE picks a requester round-robin and accepts its range, ISSUE presents
// the latched range to the reader, STREAM steers the reader's data stream
// to the owner until the last beat transfers.
//   clk, rst                      : clock, async active-high reset
//   req_arb_*                     : per-requester range requests
//   arb_req_rdy                   : one-hot request accept (IDLE only)
//   arb_reader_req_*              : range request to the log reader
//   reader_arb_data_*             : log reader output stream
//   arb_reader_data_rdy           : backpressure to the log reader
//   arb_req_data_*                : stream to the owner (payload broadcast)
//   arb_busy                      : high whenever not IDLE
module log_reader_arbiter
  import beehive_vr_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int LOG_PADBYTES_W = $clog2(LOG_W/8)
) (
  input  logic                                          clk,
  input  logic                                          rst,

  input  logic [NUM_REQ-1:0]                            req_arb_val,
  input  logic [NUM_REQ-1:0][LOG_HDR_DEPTH_W:0]         req_arb_addr_start,
  input  logic [NUM_REQ-1:0][LOG_HDR_DEPTH_W:0]         req_arb_addr_end,
  output logic [NUM_REQ-1:0]                            arb_req_rdy,

  output logic                                          arb_reader_req_val,
  output logic [LOG_HDR_DEPTH_W:0]                      arb_reader_addr_start,
  output logic [LOG_HDR_DEPTH_W:0]                      arb_reader_addr_end,
  input  logic                                          reader_arb_req_rdy,

  input  logic                                          reader_arb_data_val,
  input  logic [INT_W-1:0]                              reader_arb_last_view,
  input  logic [UDP_LENGTH_W-1:0]                       reader_arb_entries_len,
  input  logic [LOG_W-1:0]                              reader_arb_data,
  input  logic [LOG_PADBYTES_W-1:0]                     reader_arb_padbytes,
  input  logic                                          reader_arb_last,
  output logic                                          arb_reader_data_rdy,

  output logic [NUM_REQ-1:0]                            arb_req_data_val,
  output logic [NUM_REQ-1:0]                            arb_req_data_last,
  output logic [INT_W-1:0]                              arb_req_last_view,
  output logic [UDP_LENGTH_W-1:0]                       arb_req_entries_len,
  output logic [LOG_W-1:0]                              arb_req_data,
  output logic [LOG_PADBYTES_W-1:0]                     arb_req_padbytes,
  input  logic [NUM_REQ-1:0]                            req_arb_data_rdy,

  output logic                                          arb_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       last_served;
  logic [IDX_W-1:0]       owner;
  logic [LOG_HDR_DEPTH_W:0] addr_start_q;
  logic [LOG_HDR_DEPTH_W:0] addr_end_q;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_val;
  logic                   last_xfer;

  log_reader_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req       (req_arb_val),
    .last_idx  (last_served),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_val (grant_val)
  );

  assign last_xfer = reader_arb_data_val & arb_reader_data_rdy & reader_arb_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_served  <= IDX_W'(NUM_REQ-1);
      owner        <= '0;
      addr_start_q <= '0;
      addr_end_q   <= '0;
    end else begin
      case (state)
        IDLE: if (grant_val) begin
          owner        <= grant_idx;
          addr_start_q <= req_arb_addr_start[grant_idx];
          addr_end_q   <= req_arb_addr_end[grant_idx];
          state        <= ISSUE;
        end
        ISSUE: if (reader_arb_req_rdy) state <= STREAM;
        STREAM: if (last_xfer) begin
          last_served <= owner;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accept is combinational so the winner sees rdy in the cycle it is
  // picked; gated by rst so nothing is accepted while reset is held.
  assign arb_req_rdy           = (state == IDLE && !rst) ? grant : '0;
  assign arb_reader_req_val    = (state == ISSUE);
  assign arb_reader_addr_start = addr_start_q;
  assign arb_reader_addr_end   = addr_end_q;
  assign arb_busy              = (state != IDLE);
  assign arb_reader_data_rdy   = (state == STREAM) & req_arb_data_rdy[owner];

  always_comb begin
    arb_req_data_val  = '0;
    arb_req_data_last = '0;
    if (state == STREAM) begin
      arb_req_data_val[owner]  = reader_arb_data_val;
      arb_req_data_last[owner] = reader_arb_data_val & reader_arb_last;
    end
  end

  // Payload fields are shared by all requesters; only valid/last steer.
  assign arb_req_last_view   = reader_arb_last_view;
  assign arb_req_entries_len = reader_arb_entries_len;
  assign arb_req_data        = reader_arb_data;
  assign arb_req_padbytes    = reader_arb_padbytes;

endmodule

// File: tb/tb_log_reader_arbiter.sv
module tb_log_reader_arbiter;
  import beehive_vr_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int PB_W    = $clog2(LOG_W/8);
  localparam int AW      = LOG_HDR_DEPTH_W + 1;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [NUM_REQ-1:0]           req_arb_val = '0;
  logic [NUM_REQ-1:0][AW-1:0]   req_arb_addr_start = '0;
  logic [NUM_REQ-1:0][AW-1:0]   req_arb_addr_end = '0;
  logic [NUM_REQ-1:0]           arb_req_rdy;
  logic                         arb_reader_req_val;
  logic [AW-1:0]                arb_reader_addr_start;
  logic [AW-1:0]                arb_reader_addr_end;
  logic                         reader_arb_req_rdy = 1'b0;
  logic                         reader_arb_data_val = 1'b0;
  logic [INT_W-1:0]             reader_arb_last_view = '0;
  logic [UDP_LENGTH_W-1:0]      reader_arb_entries_len = '0;
  logic [LOG_W-1:0]             reader_arb_data = '0;
  logic [PB_W-1:0]              reader_arb_padbytes = '0;
  logic                         reader_arb_last = 1'b0;
  logic                         arb_reader_data_rdy;
  logic [NUM_REQ-1:0]           arb_req_data_val;
  logic [NUM_REQ-1:0]           arb_req_data_last;
  logic [INT_W-1:0]             arb_req_last_view;
  logic [UDP_LENGTH_W-1:0]      arb_req_entries_len;
  logic [LOG_W-1:0]             arb_req_data;
  logic [PB_W-1:0]              arb_req_padbytes;
  logic [NUM_REQ-1:0]           req_arb_data_rdy = '1;
  logic                         arb_busy;

  log_reader_arbiter #(.NUM_REQ(NUM_REQ), .LOG_PADBYTES_W(PB_W)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_arb_val            (req_arb_val),
    .req_arb_addr_start     (req_arb_addr_start),
    .req_arb_addr_end       (req_arb_addr_end),
    .arb_req_rdy            (arb_req_rdy),
    .arb_reader_req_val     (arb_reader_req_val),
    .arb_reader_addr_start  (arb_reader_addr_start),
    .arb_reader_addr_end    (arb_reader_addr_end),
    .reader_arb_req_rdy     (reader_arb_req_rdy),
    .reader_arb_data_val    (reader_arb_data_val),
    .reader_arb_last_view   (reader_arb_last_view),
    .reader_arb_entries_len (reader_arb_entries_len),
    .reader_arb_data        (reader_arb_data),
    .reader_arb_padbytes    (reader_arb_padbytes),
    .reader_arb_last        (reader_arb_last),
    .arb_reader_data_rdy    (arb_reader_data_rdy),
    .arb_req_data_val       (arb_req_data_val),
    .arb_req_data_last      (arb_req_data_last),
    .arb_req_last_view      (arb_req_last_view),
    .arb_req_entries_len    (arb_req_entries_len),
    .arb_req_data           (arb_req_data),
    .arb_req_padbytes       (arb_req_padbytes),
    .req_arb_data_rdy       (req_arb_data_rdy),
    .arb_busy               (arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LOG_W-1:0] data;
    logic             last;
  } beat_t;

  beat_t        sb[$];
  int           errors = 0;
  int           checks = 0;
  int           last_m = NUM_REQ - 1;   // model of last-served requester
  logic [AW-1:0] s_tab [NUM_REQ];
  logic [AW-1:0] e_tab [NUM_REQ];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_winner(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive_addrs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_arb_addr_start[i] = s_tab[i];
      req_arb_addr_end[i]   = e_tab[i];
    end
  endtask

  // One full request/stream transaction; the winner comes from the model.
  task automatic run_txn(input int nbeats, input int stall_beat, input int stall_len,
                         input int req_stall, input int abort_beat);
    int p;
    int got;
    logic [NUM_REQ-1:0] oh;
    logic [LOG_W-1:0] d;
    logic [INT_W-1:0] lv;
    logic [UDP_LENGTH_W-1:0] el;
    logic [PB_W-1:0] pb;
    beat_t e;
    drive_addrs();
    #1;
    p = exp_winner(req_arb_val, last_m);
    checks++;
    if (p < 0) begin
      errors++;
      $display("FAIL txn_setup: no valid requester, val=%b", req_arb_val);
      return;
    end
    oh = '0;
    oh[p] = 1'b1;
    if (arb_req_rdy !== oh || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL grant: rdy=%b busy=%b want rdy=%b busy=0", arb_req_rdy, arb_busy, oh);
    end
    tick();
    req_arb_val[p] = 1'b0;
    #1;
    checks++;
    if (arb_reader_req_val !== 1'b1 || arb_reader_addr_start !== s_tab[p] ||
        arb_reader_addr_end !== e_tab[p] || arb_req_rdy !== '0 || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL issue: val=%b start=%h end=%h rdy=%b busy=%b want 1 %h %h 0 1",
               arb_reader_req_val, arb_reader_addr_start, arb_reader_addr_end,
               arb_req_rdy, arb_busy, s_tab[p], e_tab[p]);
    end
    // reader data offered during ISSUE must be refused
    reader_arb_data_val = 1'b1;
    #1;
    checks++;
    if (arb_reader_data_rdy !== 1'b0 || arb_req_data_val !== '0) begin
      errors++;
      $display("FAIL issue_data_ignored: rdy=%b val=%b want 0 0", arb_reader_data_rdy, arb_req_data_val);
    end
    for (int i = 0; i < req_stall; i++) begin
      tick();
      checks++;
      if (arb_reader_req_val !== 1'b1 || arb_reader_addr_start !== s_tab[p] ||
          arb_reader_addr_end !== e_tab[p] || arb_req_rdy !== '0 || arb_reader_data_rdy !== 1'b0) begin
        errors++;
        $display("FAIL issue_stall[%0d]: val=%b start=%h end=%h rdy=%b drdy=%b want 1 %h %h 0 0",
                 i, arb_reader_req_val, arb_reader_addr_start, arb_reader_addr_end,
                 arb_req_rdy, arb_reader_data_rdy, s_tab[p], e_tab[p]);
      end
    end
    reader_arb_data_val = 1'b0;
    reader_arb_req_rdy  = 1'b1;
    tick();
    reader_arb_req_rdy  = 1'b0;
    got = 0;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < LOG_W/32; k++) d[k*32 +: 32] = $urandom;
      lv = $urandom;
      el = UDP_LENGTH_W'($urandom);
      pb = PB_W'($urandom);
      reader_arb_data        = d;
      reader_arb_last_view   = lv;
      reader_arb_entries_len = el;
      reader_arb_padbytes    = pb;
      reader_arb_last        = (b == nbeats - 1);
      reader_arb_data_val    = 1'b1;
      sb.push_back('{data: d, last: (b == nbeats - 1)});
      if (b == abort_beat) begin
        rst = 1'b1;
        #1;
        checks++;
        if ({arb_req_rdy, arb_reader_req_val, arb_reader_data_rdy, arb_req_data_val,
             arb_req_data_last, arb_busy} !== '0) begin
          errors++;
          $display("FAIL abort_immediate: rdy=%b rval=%b drdy=%b dval=%b dlast=%b busy=%b want all 0",
                   arb_req_rdy, arb_reader_req_val, arb_reader_data_rdy, arb_req_data_val,
                   arb_req_data_last, arb_busy);
        end
        tick();
        checks++;
        if ({arb_req_rdy, arb_reader_req_val, arb_reader_data_rdy, arb_req_data_val,
             arb_req_data_last, arb_busy} !== '0) begin
          errors++;
          $display("FAIL abort_next_cycle: rdy=%b rval=%b drdy=%b dval=%b dlast=%b busy=%b want all 0",
                   arb_req_rdy, arb_reader_req_val, arb_reader_data_rdy, arb_req_data_val,
                   arb_req_data_last, arb_busy);
        end
        rst = 1'b0;
        reader_arb_data_val = 1'b0;
        reader_arb_last     = 1'b0;
        req_arb_data_rdy    = '1;
        req_arb_val         = '0;
        sb.delete();
        last_m = NUM_REQ - 1;
        return;
      end
      if (b == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          req_arb_data_rdy = ~oh;   // non-owner ready must not leak through
          #1;
          checks++;
          if (arb_reader_data_rdy !== 1'b0 || arb_req_data_val !== oh) begin
            errors++;
            $display("FAIL backpressure[%0d]: drdy=%b dval=%b want 0 %b", s,
                     arb_reader_data_rdy, arb_req_data_val, oh);
          end
          tick();
        end
      end
      req_arb_data_rdy = oh;        // non-owner ready low must not block
      #1;
      checks++;
      if (arb_req_data_val !== oh || arb_reader_data_rdy !== 1'b1) begin
        errors++;
        $display("FAIL stream_hs beat %0d: dval=%b drdy=%b want %b 1", b,
                 arb_req_data_val, arb_reader_data_rdy, oh);
      end
      if (arb_req_data_val[p] && req_arb_data_rdy[p]) begin
        got++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: beat %0d delivered with empty queue", b);
        end else begin
          e = sb.pop_front();
          if (arb_req_data !== e.data || arb_req_data_last !== (e.last ? oh : '0) ||
              arb_req_last_view !== lv || arb_req_entries_len !== el || arb_req_padbytes !== pb) begin
            errors++;
            $display("FAIL beat %0d: data_lo=%h last=%b lv=%h el=%h pb=%h want data_lo=%h last=%b lv=%h el=%h pb=%h",
                     b, arb_req_data[63:0], arb_req_data_last, arb_req_last_view, arb_req_entries_len,
                     arb_req_padbytes, e.data[63:0], (e.last ? oh : '0), lv, el, pb);
          end
        end
      end
      tick();
    end
    reader_arb_data_val = 1'b0;
    reader_arb_last     = 1'b0;
    req_arb_data_rdy    = '1;
    #1;
    checks++;
    if (arb_busy !== 1'b0 || arb_req_data_val !== '0 || sb.size() != 0 || got != nbeats) begin
      errors++;
      $display("FAIL txn_end: busy=%b dval=%b queue=%0d beats=%0d want 0 0 0 %0d",
               arb_busy, arb_req_data_val, sb.size(), got, nbeats);
    end
    last_m = p;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    last_m = NUM_REQ - 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_arb_val = '1;
    reader_arb_data_val = 1'b1;
    reader_arb_req_rdy  = 1'b1;
    tick();
    tick();
    checks++;
    if ({arb_req_rdy, arb_reader_req_val, arb_reader_data_rdy, arb_req_data_val,
         arb_req_data_last, arb_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rval=%b drdy=%b dval=%b dlast=%b busy=%b want all 0",
               arb_req_rdy, arb_reader_req_val, arb_reader_data_rdy, arb_req_data_val,
               arb_req_data_last, arb_busy);
    end
    req_arb_val = '0;
    reader_arb_req_rdy = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (arb_reader_data_rdy !== 1'b0 || arb_req_data_val !== '0 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_data_ignored: drdy=%b dval=%b busy=%b want 0 0 0",
               arb_reader_data_rdy, arb_req_data_val, arb_busy);
    end
    reader_arb_data_val = 1'b0;
    last_m = NUM_REQ - 1;
  endtask

  task automatic test_single();
    s_tab[0] = 9'd3;
    e_tab[0] = 9'd5;
    req_arb_val = 2'b01;
    run_txn(4, -1, 0, 0, -1);
  endtask

  task automatic test_round_robin();
    do_reset();
    s_tab[0] = 9'h010; e_tab[0] = 9'h012;
    s_tab[1] = 9'h020; e_tab[1] = 9'h023;
    req_arb_val = 2'b11;
    run_txn(2, -1, 0, 0, -1);   // requester 0 first
    run_txn(3, -1, 0, 0, -1);   // requester 1 still waiting, served next
    req_arb_val = 2'b11;
    run_txn(1, -1, 0, 0, -1);   // back to 0
    run_txn(2, -1, 0, 0, -1);
  endtask

  task automatic test_backpressure();
    s_tab[1] = 9'h040; e_tab[1] = 9'h045;
    req_arb_val = 2'b10;
    run_txn(6, 2, 5, 0, -1);
  endtask

  task automatic test_wrap();
    s_tab[0] = 9'h1FE;
    e_tab[0] = 9'h001;
    req_arb_val = 2'b01;
    run_txn(2, -1, 0, 0, -1);
  endtask

  task automatic test_issue_stall();
    s_tab[0] = 9'h0A0; e_tab[0] = 9'h0A1;
    s_tab[1] = 9'h1B0; e_tab[1] = 9'h1B1;
    req_arb_val = 2'b11;
    run_txn(2, -1, 0, 10, -1);
    run_txn(2, -1, 0, 0, -1);
  endtask

  task automatic test_reset_mid_stream();
    s_tab[0] = 9'h050; e_tab[0] = 9'h053;
    req_arb_val = 2'b01;
    run_txn(4, -1, 0, 0, 1);    // reset during beat 2
    s_tab[1] = 9'h060; e_tab[1] = 9'h061;
    req_arb_val = 2'b10;
    run_txn(2, -1, 0, 0, -1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_issue_stall();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

endmodule
